// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, issues one word read per instruction,
// latches the returned word for the decoder and selects the next PC on retire.
// Optional memory-wait watchdog and jump-target alignment check: IFETCH_WATCHDOG_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned TIMEOUT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pc_mux_sel,
  input  logic        branch_taken,
  input  logic [31:0] reg_target,
  input  logic        advance,
  input  logic        stall,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_JUMP = 2'b10;

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_FETCH = 2'b01,
    S_ISSUE = 2'b10
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        capture;
  logic        retire;
  logic [31:0] br_offset;
  logic [31:0] next_pc;
  logic [31:0] pc_load;

`ifdef IFETCH_WATCHDOG_EN
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~TIMEOUT_W'(1);
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 fault_set;
`endif

  assign imem_addr = pc;

  // Next-PC selection from the registered pc/pc_plus4 and current instruction
  always_comb begin
    br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    next_pc   = pc_plus4;
    case (pc_mux_sel)
      SEL_REG:  next_pc = reg_target;
      SEL_BR:   next_pc = branch_taken ? (pc_plus4 + br_offset) : pc_plus4;
      SEL_JUMP: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      default:  next_pc = pc_plus4;
    endcase
`ifdef IFETCH_WATCHDOG_EN
    pc_load = next_pc & ~32'h3;
`else
    pc_load = next_pc;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_BOOT;
    else       state <= state_next;
  end

  // Next-state and control decode
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    retire     = 1'b0;
`ifdef IFETCH_WATCHDOG_EN
    fault_set  = 1'b0;
`endif
    case (state)
      S_BOOT: state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          capture    = 1'b1;
          state_next = S_ISSUE;
        end
`ifdef IFETCH_WATCHDOG_EN
        else if (wd_cnt == WD_LAST) begin
          fault_set  = 1'b1;
          state_next = S_BOOT;
        end
`endif
      end
      S_ISSUE: begin
        if (advance && !stall) begin
          retire     = 1'b1;
          state_next = S_FETCH;
`ifdef IFETCH_WATCHDOG_EN
          if (pc_mux_sel == SEL_REG && reg_target[1:0] != 2'b00) fault_set = 1'b1;
`endif
        end
      end
      default: state_next = S_BOOT;
    endcase
  end

  // PC, instruction register and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pc_plus4    <= RESET_PC + 32'd4;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      if (retire) begin
        pc       <= pc_load;
        pc_plus4 <= pc_load + 32'd4;
      end
      if (capture) instr <= imem_rdata;
      imem_req    <= (state_next == S_FETCH);
      instr_valid <= (state_next == S_ISSUE);
    end
  end

`ifdef IFETCH_WATCHDOG_EN
  // Memory-wait counter, cleared whenever not waiting in S_FETCH
  always_ff @(posedge clk) begin
    if (reset || state != S_FETCH) wd_cnt <= '0;
    else if (!imem_ready)          wd_cnt <= wd_cnt + TIMEOUT_W'(1);
  end

  // Sticky fault flag
  always_ff @(posedge clk) begin
    if (reset)          fault <= 1'b0;
    else if (fault_set) fault <= 1'b1;
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; inputs driven and outputs sampled on the falling edge.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pc_mux_sel;
  logic        branch_taken;
  logic [31:0] reg_target;
  logic        advance;
  logic        stall;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .pc_mux_sel(pc_mux_sel), .branch_taken(branch_taken),
    .reg_target(reg_target), .advance(advance), .stall(stall), .imem_addr(imem_addr),
    .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Memory answers one cycle after the request is first seen
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check1("req_seen", imem_req, 1'b1);
    check32("fetch_addr", imem_addr, exp_addr);
    tick();
    check1("req_wait", imem_req, 1'b1);
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    check1("valid_issue", instr_valid, 1'b1);
    check1("req_issue", imem_req, 1'b0);
    check32("instr", instr, word);
  endtask

  // Retire the current instruction with the given select, then check the new pc
  task automatic retire(input logic [1:0] sel, input logic taken, input logic [31:0] tgt,
                        input logic [31:0] exp_pc);
    pc_mux_sel   = sel;
    branch_taken = taken;
    reg_target   = tgt;
    advance      = 1'b1;
    tick();
    advance      = 1'b0;
    pc_mux_sel   = 2'b11;
    branch_taken = 1'b0;
    check32("next_pc", pc, exp_pc);
    check1("valid_drop", instr_valid, 1'b0);
    check1("req_refetch", imem_req, 1'b1);
  endtask

  initial begin
    reset        = 1'b1;
    pc_mux_sel   = 2'b11;
    branch_taken = 1'b0;
    reg_target   = 32'h0;
    advance      = 1'b0;
    stall        = 1'b0;
    imem_rdata   = 32'h0;
    imem_ready   = 1'b0;
    tick();
    tick();
    check32("rst_pc", pc, 32'h0);
    check32("rst_instr", instr, 32'h0);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_req", imem_req, 1'b0);
    check1("rst_fault", fault, 1'b0);
    reset = 1'b0;

    // Sequential flow: addresses 0, 4, 8 with a request the cycle right after retire
    fetch(32'h0, 32'h0000_0013);
    retire(2'b11, 1'b0, 32'h0, 32'h4);
    fetch(32'h4, 32'h0000_0093);
    retire(2'b11, 1'b0, 32'h0, 32'h8);
    fetch(32'h8, 32'h0000_0113);
    check32("pc_plus4_seq", pc_plus4, 32'hC);

    // Register jump to 0x100, then branch taken / not taken
    retire(2'b00, 1'b0, 32'h0000_0100, 32'h0000_0100);
    fetch(32'h100, 32'h1000_FFFE);
    retire(2'b01, 1'b1, 32'h0, 32'h0000_00FC);
    fetch(32'hFC, 32'h1000_FFFE);
    retire(2'b00, 1'b0, 32'h0000_0100, 32'h0000_0100);
    fetch(32'h100, 32'h1000_FFFE);
    retire(2'b01, 1'b0, 32'h0, 32'h0000_0104);

    // J-type jump keeps the pc_plus4 region bits
    fetch(32'h104, 32'h0000_0000);
    retire(2'b00, 1'b0, 32'h3000_0010, 32'h3000_0010);
    fetch(32'h3000_0010, 32'h0800_0040);
    retire(2'b10, 1'b0, 32'h0, 32'h3000_0100);

    // Register jump, aligned then misaligned target
    fetch(32'h3000_0100, 32'h0);
    retire(2'b00, 1'b0, 32'h0000_0A40, 32'h0000_0A40);
    check1("fault_aligned", fault, 1'b0);
    fetch(32'hA40, 32'h0);
`ifdef IFETCH_WATCHDOG_EN
    retire(2'b00, 1'b0, 32'h0000_0A42, 32'h0000_0A40);
    check1("fault_misaligned", fault, 1'b1);
`else
    retire(2'b00, 1'b0, 32'h0000_0A42, 32'h0000_0A42);
    check1("fault_tied", fault, 1'b0);
`endif

    // Stall overrides advance for five cycles, then one advance
    fetch(imem_addr, 32'hCAFE_0001);
    stall   = 1'b1;
    advance = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("stall_valid", instr_valid, 1'b1);
      check32("stall_instr", instr, 32'hCAFE_0001);
      check32("stall_pc", pc, imem_addr);
    end
    advance = 1'b0;
    stall   = 1'b0;
`ifdef IFETCH_WATCHDOG_EN
    retire(2'b11, 1'b0, 32'h0, 32'h0000_0A44);
`else
    retire(2'b11, 1'b0, 32'h0, 32'h0000_0A46);
`endif

    // Sequential wrap-around at the top of the address space
    fetch(imem_addr, 32'h0);
    retire(2'b00, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    check32("wrap_plus4", pc_plus4, 32'h0);
    fetch(32'hFFFF_FFFC, 32'h0);
    retire(2'b11, 1'b0, 32'h0, 32'h0);

    // Reset mid-fetch with a response in the same cycle is ignored
    fetch(32'h0, 32'h1234_5678);
    retire(2'b11, 1'b0, 32'h0, 32'h4);
    tick();
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    reset      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    check32("midrst_instr", instr, 32'h0);
    check32("midrst_pc", pc, 32'h0);
    check1("midrst_req", imem_req, 1'b0);
    check1("midrst_valid", instr_valid, 1'b0);
    tick();
    check1("boot_req", imem_req, 1'b1);
    check32("boot_addr", imem_addr, 32'h0);

    // Memory never answers
    for (int i = 0; i < 14; i++) tick();
    check1("wait14_req", imem_req, 1'b1);
    check1("wait14_fault", fault, 1'b0);
    tick();
`ifdef IFETCH_WATCHDOG_EN
    check1("wd_fault", fault, 1'b1);
    check1("wd_req_drop", imem_req, 1'b0);
    tick();
    check1("wd_retry_req", imem_req, 1'b1);
    check32("wd_retry_addr", imem_addr, 32'h0);
`else
    for (int i = 0; i < 5; i++) tick();
    check1("nowd_req", imem_req, 1'b1);
    check1("nowd_fault", fault, 1'b0);
    check32("nowd_addr", imem_addr, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
